// File: rtl/ti_sbox_layer_seq_pkg.sv
// Shared constants, FSM encoding and helpers for the TI S-box layer sequencer.
// Imported by the sequencer top and its writeback pipe.
package ti_sbox_layer_seq_pkg;

    localparam int SB_W    = 5;
    localparam int NSB_DEF = 32;
    localparam int PAR_DEF = 4;
    localparam int STATE_W = SB_W * NSB_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_e;

    // Index width that stays legal when there is only one slice.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_w(NSB_DEF / PAR_DEF);

endpackage

// File: rtl/ti_sbox_slice_pipe.sv
// Valid/index shift pipe matching the external S-box datapath latency.
// Its output marks which slice returns from the datapath this cycle.
module ti_sbox_slice_pipe
    import ti_sbox_layer_seq_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    logic [LAT-1:0]            r_vld;
    logic [LAT-1:0][IDX_W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_idx <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_idx[0] <= i_vld ? i_idx : '0;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign o_vld = r_vld[LAT-1];
    assign o_idx = r_idx[LAT-1];

endmodule

// File: rtl/ti_sbox_layer_seq.sv
// Streams four state shares through an external TI S-box datapath,
// PAR S-boxes per cycle, writing results back in place.
module ti_sbox_layer_seq
    import ti_sbox_layer_seq_pkg::*;
#(
    parameter int NSB    = NSB_DEF,
    parameter int PAR    = PAR_DEF,
    parameter int SB_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SB_W*NSB-1:0] din_s1,
    input  logic [SB_W*NSB-1:0] din_s2,
    input  logic [SB_W*NSB-1:0] din_s3,
    input  logic [SB_W*NSB-1:0] din_s4,
    output logic                busy,
    output logic                done,
    output logic [SB_W*NSB-1:0] dout_s1,
    output logic [SB_W*NSB-1:0] dout_s2,
    output logic [SB_W*NSB-1:0] dout_s3,
    output logic [SB_W*NSB-1:0] dout_s4,
    output logic                sb_vld,
    output logic [SB_W*PAR-1:0] sb_x_s1,
    output logic [SB_W*PAR-1:0] sb_x_s2,
    output logic [SB_W*PAR-1:0] sb_x_s3,
    output logic [SB_W*PAR-1:0] sb_x_s4,
    input  logic [SB_W*PAR-1:0] sb_y_s1,
    input  logic [SB_W*PAR-1:0] sb_y_s2,
    input  logic [SB_W*PAR-1:0] sb_y_s3,
    input  logic [SB_W*PAR-1:0] sb_y_s4
);

    localparam int W     = SB_W * NSB;
    localparam int SW    = SB_W * PAR;
    localparam int N     = NSB / PAR;
    localparam int IDX_W = idx_w(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_iss_idx;
    logic             w_load;
    logic             w_issue;
    logic             w_pipe_vld;
    logic             w_wb_vld;
    logic [IDX_W-1:0] w_wb_idx;

    // Shares live in four independent registers; nothing here mixes them.
    logic [W-1:0]  r_sh [4];
    logic [W-1:0]  w_din [4];
    logic [SW-1:0] w_y [4];
    logic [SW-1:0] w_x [4];

    assign w_din[0] = din_s1;
    assign w_din[1] = din_s2;
    assign w_din[2] = din_s3;
    assign w_din[3] = din_s4;

    assign w_y[0] = sb_y_s1;
    assign w_y[1] = sb_y_s2;
    assign w_y[2] = sb_y_s3;
    assign w_y[3] = sb_y_s4;

    assign dout_s1 = r_sh[0];
    assign dout_s2 = r_sh[1];
    assign dout_s3 = r_sh[2];
    assign dout_s4 = r_sh[3];

    assign sb_x_s1 = w_x[0];
    assign sb_x_s2 = w_x[1];
    assign sb_x_s3 = w_x[2];
    assign sb_x_s4 = w_x[3];

    assign w_issue  = (r_state == RUN);
    assign busy     = (r_state == RUN) || (r_state == DRAIN);
    assign done     = (r_state == FIN);
    assign sb_vld   = w_issue;
    assign w_wb_vld = w_pipe_vld && busy;

    ti_sbox_slice_pipe #(
        .LAT   (SB_LAT),
        .IDX_W (IDX_W)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_issue),
        .i_idx (r_iss_idx),
        .o_vld (w_pipe_vld),
        .o_idx (w_wb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_iss_idx == LAST) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_wb_vld && (w_wb_idx == LAST)) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_idx <= '0;
        end else if (w_load) begin
            r_iss_idx <= '0;
        end else if (w_issue) begin
            r_iss_idx <= r_iss_idx + 1'b1;
        end
    end

    // Only the slice being issued is ever presented to the datapath.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            w_x[s] = '0;
            for (int k = 0; k < N; k++) begin
                if (w_issue && (r_iss_idx == IDX_W'(k))) begin
                    w_x[s] = r_sh[s][W-1-SW*k -: SW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                r_sh[s] <= '0;
            end
        end else if (w_load) begin
            for (int s = 0; s < 4; s++) begin
                r_sh[s] <= w_din[s];
            end
        end else if (w_wb_vld) begin
            for (int s = 0; s < 4; s++) begin
                for (int k = 0; k < N; k++) begin
                    if (w_wb_idx == IDX_W'(k)) begin
                        r_sh[s][W-1-SW*k -: SW] <= w_y[s];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ti_sbox_layer_seq.sv
// Directed bench for the TI S-box layer sequencer: default, SB_LAT=2
// and PAR=1 builds, each driving a behavioural 4-share datapath.
module tb_ti_sbox_layer_seq;

    localparam logic [4:0] SBOX [32] = '{
        5'd1,  5'd0,  5'd25, 5'd26, 5'd17, 5'd29, 5'd21, 5'd27,
        5'd20, 5'd5,  5'd4,  5'd23, 5'd14, 5'd18, 5'd2,  5'd28,
        5'd15, 5'd8,  5'd6,  5'd3,  5'd13, 5'd7,  5'd24, 5'd16,
        5'd30, 5'd9,  5'd31, 5'd10, 5'd22, 5'd12, 5'd11, 5'd19
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [159:0] din [4];
    logic sa, sb, sc;

    logic busy_a, done_a, vld_a;
    logic busy_b, done_b, vld_b;
    logic busy_c, done_c, vld_c;
    logic [159:0] dout_a [4];
    logic [159:0] dout_b [4];
    logic [159:0] dout_c [4];
    logic [19:0] x_a [4];
    logic [19:0] y_a [4];
    logic [19:0] x_b [4];
    logic [19:0] p_b [4];
    logic [19:0] y_b [4];
    logic [4:0]  x_c [4];
    logic [4:0]  y_c [4];

    ti_sbox_layer_seq u_a (
        .clk(clk), .rst(rst), .start(sa),
        .din_s1(din[0]), .din_s2(din[1]), .din_s3(din[2]), .din_s4(din[3]),
        .busy(busy_a), .done(done_a),
        .dout_s1(dout_a[0]), .dout_s2(dout_a[1]),
        .dout_s3(dout_a[2]), .dout_s4(dout_a[3]),
        .sb_vld(vld_a),
        .sb_x_s1(x_a[0]), .sb_x_s2(x_a[1]), .sb_x_s3(x_a[2]), .sb_x_s4(x_a[3]),
        .sb_y_s1(y_a[0]), .sb_y_s2(y_a[1]), .sb_y_s3(y_a[2]), .sb_y_s4(y_a[3])
    );

    ti_sbox_layer_seq #(.SB_LAT(2)) u_b (
        .clk(clk), .rst(rst), .start(sb),
        .din_s1(din[0]), .din_s2(din[1]), .din_s3(din[2]), .din_s4(din[3]),
        .busy(busy_b), .done(done_b),
        .dout_s1(dout_b[0]), .dout_s2(dout_b[1]),
        .dout_s3(dout_b[2]), .dout_s4(dout_b[3]),
        .sb_vld(vld_b),
        .sb_x_s1(x_b[0]), .sb_x_s2(x_b[1]), .sb_x_s3(x_b[2]), .sb_x_s4(x_b[3]),
        .sb_y_s1(y_b[0]), .sb_y_s2(y_b[1]), .sb_y_s3(y_b[2]), .sb_y_s4(y_b[3])
    );

    ti_sbox_layer_seq #(.PAR(1)) u_c (
        .clk(clk), .rst(rst), .start(sc),
        .din_s1(din[0]), .din_s2(din[1]), .din_s3(din[2]), .din_s4(din[3]),
        .busy(busy_c), .done(done_c),
        .dout_s1(dout_c[0]), .dout_s2(dout_c[1]),
        .dout_s3(dout_c[2]), .dout_s4(dout_c[3]),
        .sb_vld(vld_c),
        .sb_x_s1(x_c[0]), .sb_x_s2(x_c[1]), .sb_x_s3(x_c[2]), .sb_x_s4(x_c[3]),
        .sb_y_s1(y_c[0]), .sb_y_s2(y_c[1]), .sb_y_s3(y_c[2]), .sb_y_s4(y_c[3])
    );

    // Behavioural shared S-box: shares 2..4 pass through, share 1 fixes the sum.
    function automatic logic [19:0] dp4(input logic [19:0] a, b, c, d);
        logic [19:0] u;
        logic [19:0] r;
        u = a ^ b ^ c ^ d;
        r = '0;
        for (int j = 0; j < 4; j++) r[19-5*j -: 5] = SBOX[u[19-5*j -: 5]];
        return r ^ b ^ c ^ d;
    endfunction

    function automatic logic [4:0] dp1(input logic [4:0] a, b, c, d);
        return SBOX[a ^ b ^ c ^ d] ^ b ^ c ^ d;
    endfunction

    always @(posedge clk) begin
        y_a[0] <= dp4(x_a[0], x_a[1], x_a[2], x_a[3]);
        p_b[0] <= dp4(x_b[0], x_b[1], x_b[2], x_b[3]);
        y_c[0] <= dp1(x_c[0], x_c[1], x_c[2], x_c[3]);
        for (int s = 1; s < 4; s++) begin
            y_a[s] <= x_a[s];
            p_b[s] <= x_b[s];
            y_c[s] <= x_c[s];
        end
        for (int s = 0; s < 4; s++) y_b[s] <= p_b[s];
    end

    function automatic logic [159:0] rep(input logic [4:0] v);
        return {32{v}};
    endfunction

    function automatic logic [159:0] ux(input logic [159:0] a, b, c, d);
        return a ^ b ^ c ^ d;
    endfunction

    task automatic load(input logic [159:0] x);
        din[0] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        din[1] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        din[2] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        din[3] = x ^ din[0] ^ din[1] ^ din[2];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sa = 1'b0; sb = 1'b0; sc = 1'b0;
        for (int s = 0; s < 4; s++) din[s] = '0;
        tick();
        tick();
        n_chk++;
        if ({busy_a, done_a, vld_a} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctl_a got=%b exp=000", {busy_a, done_a, vld_a});
        end
        n_chk++;
        if ((x_a[0] | x_a[1] | x_a[2] | x_a[3]) !== 20'd0) begin
            n_err++;
            $display("FAIL reset_sbx_a got=%h exp=0", x_a[0] | x_a[1] | x_a[2] | x_a[3]);
        end
        n_chk++;
        if ((dout_a[0] | dout_a[1] | dout_a[2] | dout_a[3]) !== 160'd0) begin
            n_err++;
            $display("FAIL reset_dout_a got=%h exp=0",
                     dout_a[0] | dout_a[1] | dout_a[2] | dout_a[3]);
        end
        n_chk++;
        if ({busy_b, done_b, vld_b, busy_c, done_c, vld_c} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_ctl_bc got=%b exp=0",
                     {busy_b, done_b, vld_b, busy_c, done_c, vld_c});
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        load(160'd0);
        sa = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            sa = 1'b0;
            n_chk++;
            if (busy_a !== (c <= 9)) begin
                n_err++;
                $display("FAIL zero_busy c=%0d got=%b exp=%b", c, busy_a, c <= 9);
            end
            n_chk++;
            if (done_a !== (c == 10)) begin
                n_err++;
                $display("FAIL zero_done c=%0d got=%b exp=%b", c, done_a, c == 10);
            end
        end
        n_chk++;
        if (ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]) !== rep(5'd1)) begin
            n_err++;
            $display("FAIL zero_result got=%h exp=%h",
                     ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]), rep(5'd1));
        end
    endtask

    task automatic test_ones();
        int vcnt;
        vcnt = 0;
        load(rep(5'd31));
        sa = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            sa = 1'b0;
            if (vld_a === 1'b1) vcnt++;
            if (c == 9 || c == 10) begin
                n_chk++;
                if ((x_a[0] | x_a[1] | x_a[2] | x_a[3]) !== 20'd0) begin
                    n_err++;
                    $display("FAIL ones_sbx_idle c=%0d got=%h exp=0", c,
                             x_a[0] | x_a[1] | x_a[2] | x_a[3]);
                end
            end
            n_chk++;
            if (done_a !== (c == 10)) begin
                n_err++;
                $display("FAIL ones_done c=%0d got=%b exp=%b", c, done_a, c == 10);
            end
        end
        n_chk++;
        if (vcnt != 8) begin
            n_err++;
            $display("FAIL ones_vld_cycles got=%0d exp=8", vcnt);
        end
        n_chk++;
        if (ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]) !== rep(5'd19)) begin
            n_err++;
            $display("FAIL ones_result got=%h exp=%h",
                     ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]), rep(5'd19));
        end
    endtask

    task automatic test_ramp_lat2();
        logic [159:0] x;
        logic [159:0] e;
        for (int i = 0; i < 32; i++) x[159-5*i -: 5] = i[4:0];
        load(x);
        sb = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            sb = 1'b0;
            // slice k issued in cycle k+1, written at k+3, visible from k+4
            for (int i = 0; i < 32; i++)
                e[159-5*i -: 5] = (c >= i / 4 + 4) ? SBOX[i] : i[4:0];
            n_chk++;
            if (ux(dout_b[0], dout_b[1], dout_b[2], dout_b[3]) !== e) begin
                n_err++;
                $display("FAIL lat2_slices c=%0d got=%h exp=%h", c,
                         ux(dout_b[0], dout_b[1], dout_b[2], dout_b[3]), e);
            end
            n_chk++;
            if (done_b !== (c == 11)) begin
                n_err++;
                $display("FAIL lat2_done c=%0d got=%b exp=%b", c, done_b, c == 11);
            end
            n_chk++;
            if (busy_b !== (c <= 10)) begin
                n_err++;
                $display("FAIL lat2_busy c=%0d got=%b exp=%b", c, busy_b, c <= 10);
            end
        end
    endtask

    task automatic test_back_to_back();
        load(rep(5'd3));
        sa = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            n_chk++;
            if (done_a !== (c == 10 || c == 20)) begin
                n_err++;
                $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done_a,
                         c == 10 || c == 20);
            end
            n_chk++;
            if (busy_a !== ((c <= 9) || (c >= 11 && c <= 19))) begin
                n_err++;
                $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy_a,
                         (c <= 9) || (c >= 11 && c <= 19));
            end
            if (c == 10) begin
                n_chk++;
                if (ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]) !== rep(5'd26)) begin
                    n_err++;
                    $display("FAIL b2b_first got=%h exp=%h",
                             ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]), rep(5'd26));
                end
            end
            if (c == 4) load(rep(5'd5));
            sa = (c == 4) || (c == 10);
        end
        n_chk++;
        if (ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]) !== rep(5'd29)) begin
            n_err++;
            $display("FAIL b2b_second got=%h exp=%h",
                     ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]), rep(5'd29));
        end
    endtask

    task automatic test_rst_mid();
        load(rep(5'd4));
        sa = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            sa = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({busy_a, done_a, vld_a} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_ctl got=%b exp=000", {busy_a, done_a, vld_a});
        end
        n_chk++;
        if ((x_a[0] | x_a[1] | x_a[2] | x_a[3]) !== 20'd0) begin
            n_err++;
            $display("FAIL rstmid_sbx got=%h exp=0", x_a[0] | x_a[1] | x_a[2] | x_a[3]);
        end
        n_chk++;
        if ((dout_a[0] | dout_a[1] | dout_a[2] | dout_a[3]) !== 160'd0) begin
            n_err++;
            $display("FAIL rstmid_dout got=%h exp=0",
                     dout_a[0] | dout_a[1] | dout_a[2] | dout_a[3]);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            n_chk++;
            if ({busy_a, done_a} !== 2'b00) begin
                n_err++;
                $display("FAIL rstmid_quiet c=%0d got=%b exp=00", c, {busy_a, done_a});
            end
        end
        load(rep(5'd7));
        sa = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            sa = 1'b0;
            n_chk++;
            if (done_a !== (c == 10)) begin
                n_err++;
                $display("FAIL rstmid_redo_done c=%0d got=%b exp=%b", c, done_a, c == 10);
            end
        end
        n_chk++;
        if (ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]) !== rep(5'd27)) begin
            n_err++;
            $display("FAIL rstmid_redo_result got=%h exp=%h",
                     ux(dout_a[0], dout_a[1], dout_a[2], dout_a[3]), rep(5'd27));
        end
    endtask

    task automatic test_par1();
        int vcnt;
        vcnt = 0;
        load(rep(5'd2));
        sc = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            sc = 1'b0;
            if (vld_c === 1'b1) vcnt++;
            n_chk++;
            if (done_c !== (c == 34)) begin
                n_err++;
                $display("FAIL par1_done c=%0d got=%b exp=%b", c, done_c, c == 34);
            end
            n_chk++;
            if (busy_c !== (c <= 33)) begin
                n_err++;
                $display("FAIL par1_busy c=%0d got=%b exp=%b", c, busy_c, c <= 33);
            end
        end
        n_chk++;
        if (vcnt != 32) begin
            n_err++;
            $display("FAIL par1_vld_cycles got=%0d exp=32", vcnt);
        end
        n_chk++;
        if (ux(dout_c[0], dout_c[1], dout_c[2], dout_c[3]) !== rep(5'd25)) begin
            n_err++;
            $display("FAIL par1_result got=%h exp=%h",
                     ux(dout_c[0], dout_c[1], dout_c[2], dout_c[3]), rep(5'd25));
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_ramp_lat2();
        test_back_to_back();
        test_rst_mid();
        test_par1();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
